axi_arbiter: RTL and testbench

//  Merges the core's instruction-fetch port and data-memory port into the single request port of the AXI bridge.

---
 rtl/axi_arbiter_pkg.sv | 38 +++
 rtl/arb_pending.sv | 41 ++++
 rtl/axi_arbiter.sv | 128 ++++++++++++
 tb/tb_axi_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arbiter_pkg.sv
// Shared types and helpers for the fetch/data to AXI-bridge request arbiter.
// Owner encoding, arbiter states and the latched request record live here.
package axi_arbiter_pkg;

  localparam logic OWN_IMEM = 1'b0;
  localparam logic OWN_DMEM = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // On a tie, fixed priority favours dmem; round-robin favours the port not granted last.
  function automatic logic pick_winner(input logic imem_full, input logic dmem_full,
                                       input logic last_owner, input logic fixed_prio);
    logic w;
    if (imem_full && dmem_full) begin
      if (fixed_prio) begin
        w = OWN_DMEM;
      end else begin
        w = ~last_owner;
      end
    end else if (dmem_full) begin
      w = OWN_DMEM;
    end else begin
      w = OWN_IMEM;
    end
    return w;
  endfunction

endpackage

// File: rtl/arb_pending.sv
// One-entry request latch: holds a port's request from its valid pulse until completion.
// A capture in the same cycle as the clear is accepted (set wins over clear).
module arb_pending
  import axi_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     capture,
  input  logic     clear,
  input  mem_req_t new_req,
  output logic     full,
  output mem_req_t req
);

  logic     accept_s;
  logic     full_r;
  mem_req_t req_r;

  assign accept_s = capture && (!full_r || clear);

  // A capture while already holding a request is dropped without touching stored fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_r <= 1'b0;
      req_r  <= '0;
    end else if (accept_s) begin
      full_r <= 1'b1;
      req_r  <= new_req;
    end else if (clear) begin
      full_r <= 1'b0;
      req_r  <= req_r;
    end else begin
      full_r <= full_r;
      req_r  <= req_r;
    end
  end

  assign full = full_r;
  assign req  = req_r;

endmodule

// File: rtl/axi_arbiter.sv
// Merges the fetch and data memory ports onto the single AXI bridge request port.
// One transaction in flight; axi_* driven only from latched requests, never from port inputs.
module axi_arbiter
  import axi_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        axi_valid,
  output logic        axi_instr,
  output logic [31:0] axi_addr,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic [31:0] axi_rdata,
  input  logic        axi_ready
);

  arb_state_t state_r, state_s;
  logic       owner_r, owner_s;
  logic       last_owner_r, last_owner_s;
  logic       imem_full_s, dmem_full_s;
  logic       winner_s, grant_s, done_s;
  logic       imem_clear_s, dmem_clear_s;
  logic       issue_s, imem_done_s, dmem_done_s;
  mem_req_t   imem_new_s, dmem_new_s, imem_req_s, dmem_req_s, win_req_s;

  assign imem_new_s = '{instr: 1'b1, addr: imem_addr, wdata: 32'h0000_0000, wstrb: 4'h0};
  assign dmem_new_s = '{instr: 1'b0, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

  assign imem_clear_s = done_s && (owner_r == OWN_IMEM);
  assign dmem_clear_s = done_s && (owner_r == OWN_DMEM);

  arb_pending u_imem_pending (
    .clk     (clk),
    .rst     (rst),
    .capture (imem_valid),
    .clear   (imem_clear_s),
    .new_req (imem_new_s),
    .full    (imem_full_s),
    .req     (imem_req_s)
  );

  arb_pending u_dmem_pending (
    .clk     (clk),
    .rst     (rst),
    .capture (dmem_valid),
    .clear   (dmem_clear_s),
    .new_req (dmem_new_s),
    .full    (dmem_full_s),
    .req     (dmem_req_s)
  );

  assign winner_s  = pick_winner(imem_full_s, dmem_full_s, last_owner_r, (ARB_MODE != 0));
  assign win_req_s = (winner_s == OWN_DMEM) ? dmem_req_s : imem_req_s;

  // State, owner and last-grant registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      owner_r      <= OWN_IMEM;
      last_owner_r <= OWN_IMEM;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_owner_r <= last_owner_s;
    end
  end

  // Next-state: grant from IDLE when anything is pending, complete from BUSY on bridge ready.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_owner_s = last_owner_r;
    grant_s      = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (imem_full_s || dmem_full_s) begin
          grant_s      = 1'b1;
          state_s      = BUSY;
          owner_s      = winner_s;
          last_owner_s = winner_s;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (axi_ready) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Gating with rst keeps every output quiet while reset is held.
  assign issue_s     = rst && grant_s;
  assign imem_done_s = rst && done_s && (owner_r == OWN_IMEM);
  assign dmem_done_s = rst && done_s && (owner_r == OWN_DMEM);

  assign axi_valid  = issue_s;
  assign axi_instr  = issue_s ? win_req_s.instr : 1'b0;
  assign axi_addr   = issue_s ? win_req_s.addr  : 32'h0000_0000;
  assign axi_wdata  = issue_s ? win_req_s.wdata : 32'h0000_0000;
  assign axi_wstrb  = issue_s ? win_req_s.wstrb : 4'h0;

  assign imem_ready = imem_done_s;
  assign imem_rdata = imem_done_s ? axi_rdata : 32'h0000_0000;
  assign dmem_ready = dmem_done_s;
  assign dmem_rdata = dmem_done_s ? axi_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: round-robin (a_*) and fixed-priority (b_*) instances
// share one stimulus; single transactions are table-driven, corner cases are hand sequences.
module tb_axi_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] axi_rdata;
  logic        axi_ready;

  logic [31:0] a_imem_rdata, b_imem_rdata, a_dmem_rdata, b_dmem_rdata;
  logic        a_imem_ready, b_imem_ready, a_dmem_ready, b_dmem_ready;
  logic        a_axi_valid, b_axi_valid, a_axi_instr, b_axi_instr;
  logic [31:0] a_axi_addr, b_axi_addr, a_axi_wdata, b_axi_wdata;
  logic [3:0]  a_axi_wstrb, b_axi_wstrb;

  int checks = 0;
  int errors = 0;

  axi_arbiter #(.ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_rdata(a_imem_rdata), .imem_ready(a_imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(a_dmem_rdata), .dmem_ready(a_dmem_ready),
    .axi_valid(a_axi_valid), .axi_instr(a_axi_instr), .axi_addr(a_axi_addr),
    .axi_wdata(a_axi_wdata), .axi_wstrb(a_axi_wstrb),
    .axi_rdata(axi_rdata), .axi_ready(axi_ready)
  );

  axi_arbiter #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_rdata(b_imem_rdata), .imem_ready(b_imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(b_dmem_rdata), .dmem_ready(b_dmem_ready),
    .axi_valid(b_axi_valid), .axi_instr(b_axi_instr), .axi_addr(b_axi_addr),
    .axi_wdata(b_axi_wdata), .axi_wstrb(b_axi_wstrb),
    .axi_rdata(axi_rdata), .axi_ready(axi_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  typedef struct packed {
    logic        is_dmem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        exp_instr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_axi(input string tag, input int inst, input logic v, input logic [31:0] addr,
                         input logic instr, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic vv, ii;
    logic [31:0] aa, ww;
    logic [3:0] ss;
    vv = (inst == 0) ? a_axi_valid : b_axi_valid;
    ii = (inst == 0) ? a_axi_instr : b_axi_instr;
    aa = (inst == 0) ? a_axi_addr  : b_axi_addr;
    ww = (inst == 0) ? a_axi_wdata : b_axi_wdata;
    ss = (inst == 0) ? a_axi_wstrb : b_axi_wstrb;
    chk($sformatf("%s.m%0d axi_valid", tag, inst), 32'(vv), 32'(v));
    chk($sformatf("%s.m%0d axi_instr", tag, inst), 32'(ii), 32'(instr));
    chk($sformatf("%s.m%0d axi_addr", tag, inst), aa, addr);
    chk($sformatf("%s.m%0d axi_wdata", tag, inst), ww, wdata);
    chk($sformatf("%s.m%0d axi_wstrb", tag, inst), 32'(ss), 32'(wstrb));
  endtask

  task automatic chk_port(input string tag, input int inst, input logic ir, input logic [31:0] ird,
                          input logic dr, input logic [31:0] drd);
    chk($sformatf("%s.m%0d imem_ready", tag, inst), 32'((inst == 0) ? a_imem_ready : b_imem_ready), 32'(ir));
    chk($sformatf("%s.m%0d imem_rdata", tag, inst), (inst == 0) ? a_imem_rdata : b_imem_rdata, ird);
    chk($sformatf("%s.m%0d dmem_ready", tag, inst), 32'((inst == 0) ? a_dmem_ready : b_dmem_ready), 32'(dr));
    chk($sformatf("%s.m%0d dmem_rdata", tag, inst), (inst == 0) ? a_dmem_rdata : b_dmem_rdata, drd);
  endtask

  task automatic chk_quiet(input string tag, input int inst);
    chk_axi(tag, inst, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    chk_port(tag, inst, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic idle_inputs();
    imem_valid = 1'b0; imem_addr = 32'h0; dmem_valid = 1'b0; dmem_addr = 32'h0;
    dmem_wdata = 32'h0; dmem_wstrb = 4'h0; axi_rdata = 32'h0; axi_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h1234_5678, 4'h5, 32'h0000_0013, 1'b1, 32'h0, 4'h0};
    vecs[1] = '{1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 4'hF};
    vecs[2] = '{1'b1, 32'h0000_1000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 4'h0};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, 4'h0};
    vecs[4] = '{1'b1, 32'h0000_0003, 32'h0000_00A5, 4'h1, 32'h0000_0000, 1'b0, 32'h0000_00A5, 4'h1};

    // Reset: outputs quiet while held, even with requests and bridge ready toggling.
    idle_inputs();
    rst = 1'b0;
    tick();
    imem_valid = 1'b1; imem_addr = 32'h0000_0bad; axi_ready = 1'b1; axi_rdata = 32'h1111_1111;
    #1;
    for (int m = 0; m < 2; m++) chk_quiet("in_reset", m);
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) chk_quiet("first_after_reset", m);
    tick();

    // Table: single transactions, issue at N+1 only, completion routed to the owner.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].is_dmem) begin
        dmem_valid = 1'b1; dmem_addr = vecs[i].addr;
      end else begin
        imem_valid = 1'b1; imem_addr = vecs[i].addr;
      end
      dmem_wdata = vecs[i].wdata; dmem_wstrb = vecs[i].wstrb;
      #1;
      for (int m = 0; m < 2; m++) chk_quiet($sformatf("v%0d.cycN", i), m);
      tick();
      imem_valid = 1'b0; dmem_valid = 1'b0;
      #1;
      for (int m = 0; m < 2; m++)
        chk_axi($sformatf("v%0d.issue", i), m, 1'b1, vecs[i].addr, vecs[i].exp_instr,
                vecs[i].exp_wdata, vecs[i].exp_wstrb);
      tick();
      axi_ready = 1'b1; axi_rdata = vecs[i].rdata;
      #1;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("v%0d.busy.m%0d axi_valid", i, m), 32'((m == 0) ? a_axi_valid : b_axi_valid), 32'h0);
        if (vecs[i].is_dmem)
          chk_port($sformatf("v%0d.done", i), m, 1'b0, 32'h0, 1'b1, vecs[i].rdata);
        else
          chk_port($sformatf("v%0d.done", i), m, 1'b1, vecs[i].rdata, 1'b0, 32'h0);
      end
      tick();
      idle_inputs();
      #1;
      for (int m = 0; m < 2; m++) chk_quiet($sformatf("v%0d.after", i), m);
      tick();
    end

    // Tie after reset: both modes grant dmem first, imem issued the cycle after dmem completes.
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h0000_0100;
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0200;
    tick();
    idle_inputs();
    #1;
    for (int m = 0; m < 2; m++) chk_axi("tie.grant1", m, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'h0);
    tick();
    axi_ready = 1'b1; axi_rdata = 32'h0000_0222;
    #1;
    for (int m = 0; m < 2; m++) chk_port("tie.done1", m, 1'b0, 32'h0, 1'b1, 32'h0000_0222);
    tick();
    idle_inputs();
    #1;
    for (int m = 0; m < 2; m++) chk_axi("tie.grant2", m, 1'b1, 32'h0000_0100, 1'b1, 32'h0, 4'h0);
    tick();
    axi_ready = 1'b1; axi_rdata = 32'h0000_0111;
    #1;
    for (int m = 0; m < 2; m++) chk_port("tie.done2", m, 1'b1, 32'h0000_0111, 1'b0, 32'h0);
    tick();
    idle_inputs();

    // Round-robin: three successive ties (refill on the ready cycle) grant DMEM, IMEM, DMEM.
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h0000_0300;
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0400;
    tick();
    idle_inputs();
    #1;
    chk_axi("rr.tie1", 0, 1'b1, 32'h0000_0400, 1'b0, 32'h0, 4'h0);
    tick();
    axi_ready = 1'b1; dmem_valid = 1'b1; dmem_addr = 32'h0000_0404;
    #1;
    chk_port("rr.done1", 0, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    idle_inputs();
    #1;
    chk_axi("rr.tie2", 0, 1'b1, 32'h0000_0300, 1'b1, 32'h0, 4'h0);
    tick();
    axi_ready = 1'b1; imem_valid = 1'b1; imem_addr = 32'h0000_0304;
    #1;
    chk_port("rr.done2", 0, 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    #1;
    chk_axi("rr.tie3", 0, 1'b1, 32'h0000_0404, 1'b0, 32'h0, 4'h0);
    tick();

    // Protocol violation: repeated dmem_valid while pending and in flight is dropped.
    do_reset();
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0040;
    tick();
    dmem_addr = 32'h0000_0044;
    #1;
    for (int m = 0; m < 2; m++) chk_axi("viol.issue", m, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 4'h0);
    tick();
    #1;
    for (int m = 0; m < 2; m++) chk_quiet("viol.busy", m);
    tick();
    idle_inputs();
    axi_ready = 1'b1; axi_rdata = 32'h0000_0055;
    #1;
    for (int m = 0; m < 2; m++) chk_port("viol.done", m, 1'b0, 32'h0, 1'b1, 32'h0000_0055);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int m = 0; m < 2; m++) chk_quiet($sformatf("viol.tail%0d", c), m);
      tick();
    end

    // Reset mid-transaction with imem pending: nothing completes, nothing reissues.
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h0000_0500;
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0600;
    tick();
    idle_inputs();
    tick();
    rst = 1'b0; axi_ready = 1'b1; axi_rdata = 32'h0000_0666;
    #1;
    for (int m = 0; m < 2; m++) chk_quiet("rst_mid.held", m);
    tick();
    rst = 1'b1;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int m = 0; m < 2; m++) chk_quiet($sformatf("rst_mid.after%0d", c), m);
      tick();
    end
    imem_valid = 1'b1; imem_addr = 32'h0000_0700;
    tick();
    idle_inputs();
    #1;
    for (int m = 0; m < 2; m++) chk_axi("rst_mid.new", m, 1'b1, 32'h0000_0700, 1'b1, 32'h0, 4'h0);
    tick();
    axi_ready = 1'b1; axi_rdata = 32'h0000_0777;
    #1;
    for (int m = 0; m < 2; m++) chk_port("rst_mid.done", m, 1'b1, 32'h0000_0777, 1'b0, 32'h0);
    tick();
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
